// File: rtl/fa_bist_pkg.sv
// Shared encodings and sizes for the full-adder BIST controller and its golden model.
package fa_bist_pkg;

  localparam int VEC_W       = 3;
  localparam int NUM_VECTORS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_golden.sv
// Combinational reference full adder used to judge the adder under test.
module fa_golden (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic exp_s_o,
  output logic exp_cout_o
);

  assign exp_s_o    = a_i ^ b_i ^ cin_i;
  assign exp_cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/fa_bist.sv
// BIST controller: sweeps all {a,b,cin} vectors into an external full adder,
// samples its outputs after a settle window and scores them against fa_golden.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic             dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = $clog2(PASSES + 1);

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [PASS_W-1:0]   pcnt_q, pcnt_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                ffv_q, ffv_d;
  logic [VEC_W-1:0]    ffvec_q, ffvec_d;
  logic                pass_q, pass_d;

  logic exp_s, exp_cout;
  logic sample, mismatch, last_vec;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  fa_golden u_golden (
    .a_i       (vec_q[2]),
    .b_i       (vec_q[1]),
    .cin_i     (vec_q[0]),
    .exp_s_o   (exp_s),
    .exp_cout_o(exp_cout)
  );

  assign sample   = (state_q == DRIVE) && (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign mismatch = sample && ({dut_s, dut_cout} != {exp_s, exp_cout});
  assign last_vec = (vec_q == VEC_W'(NUM_VECTORS - 1)) && (pcnt_q == PASS_W'(PASSES - 1));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          vec_d    = '0;
          settle_d = '0;
          pcnt_d   = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          pass_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (sample) begin
          settle_d = '0;
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          // vec wraps to 000 after the last vector, so the DUT inputs return to 0 in DONE
          vec_d = vec_q + VEC_W'(1);
          if (vec_q == VEC_W'(NUM_VECTORS - 1)) pcnt_d = pcnt_q + PASS_W'(1);
          if (last_vec) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      pcnt_q   <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      pass_q   <= pass_d;
    end
  end

  assign {dut_a, dut_b, dut_cin} = vec_q;
  assign busy             = (state_q == DRIVE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
